instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream feeder for the multi-cycle MIPS datapath core (`mipscpu`).
- Holds the PC, a writable instruction memory and the branch/jump next-PC logic.
- Presents one 32-bit instruction word per instruction slot, with a one-cycle `newinstr` pulse that restarts the control FSM.
- Programmed through a load port while idle; runs until it fetches a halt word.

Parameters:
- IMEM_DEPTH, 64, instruction memory depth in words (power of 2); AW = log2(IMEM_DEPTH).
- CYCLES_PER_INSTR, 4, clock cycles per instruction slot (minimum 2).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse in IDLE begins execution at word 0.
- load_en  in  1  write enable for the instruction memory (honoured in IDLE only).
- load_addr  in  AW  word address of the instruction memory write.
- load_data  in  32  instruction word to write.
- alu_zero  in  1  ALU zero flag from the datapath, used for beq.
- instrword  out  32  current instruction, registered.
- newinstr  out  1  high during the first cycle of each slot, registered.
- pc_out  out  32  byte address of instrword: {pc, 2'b00}, zero-extended.
- halted  out  1  high in HALT.
- busy  out  1  high in RUN.
- instr_count  out  16  number of instructions issued, saturating at 0xFFFF.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values: state=IDLE, pc=0, slot_cnt=0, instrword=0, newinstr=0, instr_count=0, halted=0, busy=0.
- Reset does not clear the instruction memory. Reset asserted mid-RUN or in HALT returns to IDLE at the next edge.
- States: IDLE, RUN, HALT.
- IDLE behaviour:
  - load_en=1 and start=0: imem[load_addr] <= load_data.
  - start=1: load is ignored. If imem[0][31:26]==6'h3F, go to HALT with pc=0 and instrword unchanged. Otherwise go to RUN with pc=0, instrword<=imem[0], newinstr<=1, slot_cnt<=0, instr_count+1.
- RUN, each edge:
  - If slot_cnt != N-1: slot_cnt+1, newinstr<=0.
  - If slot_cnt == N-1 (slot end): compute next_pc, then evaluate w = imem[next_pc].
    - If w[31:26]==6'h3F: go to HALT, pc<=next_pc, newinstr<=0, instrword held.
    - Otherwise: pc<=next_pc, instrword<=w, newinstr<=1, slot_cnt<=0, instr_count+1 (saturating).
- RUN ignores start and load_en.
- next_pc rules (word addressing, modulo IMEM_DEPTH, wrap-around silent):
  - opcode 6'd4 (beq) and alu_zero==1, sampled at slot end: pc + 1 + sign_extend(instrword[15:0]).
  - opcode 6'd2 (j): instrword[AW-1:0].
  - otherwise: pc + 1; pc = IMEM_DEPTH-1 wraps to 0.
- Latency: each instruction occupies exactly CYCLES_PER_INSTR cycles. No bubble between slots.
- HALT: outputs held, newinstr=0. Leaves only on reset. start is ignored.
- Outputs:
  - busy = (state==RUN); halted = (state==HALT).
  - pc_out tracks pc in every state.
  - instr_count is not incremented for halt words.

Test Plan:
- Load imem[0..2] = 0x00221820, 0x8C040004, 0xFC000000; reset; start → newinstr pulses at cycles 1 and 5 after the start edge; instrword 0x00221820 then 0x8C040004; halted=1 at cycle 9; instr_count=2; pc_out=0x8.
- Load imem[0]=0x08000005, imem[5]=0x00000020, imem[6]=0xFC000000; start → instrword sequence 0x08000005, then 0x00000020 with pc_out=0x14, then HALT.
- Load imem[2]=0x1000FFFE; hold alu_zero=1 at slot end of pc=2 → next instrword is imem[1], pc_out=0x4. Repeat with alu_zero=0 → imem[3], pc_out=0xC.
- Load imem[63] non-halt and imem[0] non-halt; reach pc=63 → next pc wraps to 0, pc_out=0x0.
- Assert reset at slot_cnt=2 of the second instruction → next edge: IDLE, instrword=0, newinstr=0, pc_out=0, instr_count=0. imem contents intact, so a re-start replays the same first word.
- In IDLE, assert load_en=1 with start=1 for imem[0] → write suppressed and imem[0] keeps its old value. load_en pulses during RUN and HALT → memory unchanged.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the multi-cycle MIPS core: PC, loadable instruction
// memory and beq/j next-PC logic, issuing one instruction word per fixed-length slot.
module instr_fetch_unit #(
    parameter int IMEM_DEPTH       = 64,
    parameter int CYCLES_PER_INSTR = 4,
    localparam int AW              = $clog2(IMEM_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          alu_zero,
    output logic [31:0]   instrword,
    output logic          newinstr,
    output logic [31:0]   pc_out,
    output logic          halted,
    output logic          busy,
    output logic [15:0]   instr_count
);

    localparam int SW = $clog2(CYCLES_PER_INSTR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic [31:0]   imem [IMEM_DEPTH];
    logic [1:0]    state;
    logic [AW-1:0] pc;
    logic [SW-1:0] slot_cnt;

    logic [AW-1:0] pc_seq;
    logic [AW-1:0] br_off;
    logic [AW-1:0] next_pc;
    logic [31:0]   fetch_word;
    logic [31:0]   word0;
    logic          slot_end;
    logic [15:0]   cnt_inc;

    function automatic logic is_halt(input logic [31:0] w);
        return w[31:26] == OP_HALT;
    endfunction

    // Branch offset reduced to the PC width; sign extension only matters if AW > 16.
    generate
        if (AW <= 16) begin : g_off_narrow
            assign br_off = instrword[AW-1:0];
        end else begin : g_off_wide
            assign br_off = {{(AW-16){instrword[15]}}, instrword[15:0]};
        end
    endgenerate

    assign pc_seq = pc + AW'(1);

    always_comb begin
        next_pc = pc_seq;
        if (instrword[31:26] == OP_BEQ && alu_zero)
            next_pc = pc_seq + br_off;
        else if (instrword[31:26] == OP_J)
            next_pc = instrword[AW-1:0];
    end

    assign fetch_word = imem[next_pc];
    assign word0      = imem[0];
    assign slot_end   = (slot_cnt == SW'(CYCLES_PER_INSTR - 1));
    assign cnt_inc    = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;

    // Memory has no reset so a program survives a reset and can be replayed.
    always_ff @(posedge clock) begin
        if (!reset && state == S_IDLE && load_en && !start)
            imem[load_addr] <= load_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            slot_cnt    <= '0;
            instrword   <= '0;
            newinstr    <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    newinstr <= 1'b0;
                    if (start) begin
                        pc <= '0;
                        if (is_halt(word0)) begin
                            state <= S_HALT;
                        end else begin
                            state       <= S_RUN;
                            instrword   <= word0;
                            newinstr    <= 1'b1;
                            slot_cnt    <= '0;
                            instr_count <= cnt_inc;
                        end
                    end
                end
                S_RUN: begin
                    if (slot_end) begin
                        pc <= next_pc;
                        if (is_halt(fetch_word)) begin
                            state    <= S_HALT;
                            newinstr <= 1'b0;
                        end else begin
                            instrword   <= fetch_word;
                            newinstr    <= 1'b1;
                            slot_cnt    <= '0;
                            instr_count <= cnt_inc;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + SW'(1);
                        newinstr <= 1'b0;
                    end
                end
                S_HALT: newinstr <= 1'b0;
                default: begin
                    state    <= S_IDLE;
                    newinstr <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out = {{(30-AW){1'b0}}, pc, 2'b00};
    assign busy   = (state == S_RUN);
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed programs plus random programs checked
// against an instruction-level model of fetch, branch and halt behaviour.
module tb_instr_fetch_unit;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int N     = 4;

    logic          clock = 1'b0;
    logic          reset, start, load_en, alu_zero;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [31:0]   instrword, pc_out;
    logic          newinstr, halted, busy;
    logic [15:0]   instr_count;

    instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .CYCLES_PER_INSTR(N)) dut (
        .clock(clock), .reset(reset), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .alu_zero(alu_zero),
        .instrword(instrword), .newinstr(newinstr), .pc_out(pc_out),
        .halted(halted), .busy(busy), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_imem [DEPTH];
    int          m_cnt;
    logic [31:0] m_iw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] iw, input int pcb,
                           input bit nw, input bit bsy, input bit hlt);
        chk({tag, ".instrword"}, instrword, iw);
        chk({tag, ".pc_out"}, pc_out, pcb);
        chk({tag, ".newinstr"}, {31'd0, newinstr}, {31'd0, nw});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, hlt});
        chk({tag, ".instr_count"}, {16'd0, instr_count}, m_cnt);
    endtask

    function automatic bit is_halt(input logic [31:0] w);
        return w[31:26] == 6'h3F;
    endfunction

    // Next word address from the ISA rules, using plain integer arithmetic.
    function automatic int model_next(input int pc, input logic [31:0] iw, input bit z);
        int off;
        if (iw[31:26] == 6'd4 && z) begin
            off = int'($signed(iw[15:0]));
            return (((pc + 1 + off) % DEPTH) + DEPTH) % DEPTH;
        end
        if (iw[31:26] == 6'd2) return int'(iw[25:0]) % DEPTH;
        return (pc + 1) % DEPTH;
    endfunction

    task automatic sat_inc;
        if (m_cnt < 65535) m_cnt++;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step;
        reset = 1'b0;
        m_cnt = 0;
        m_iw  = 32'd0;
        chk_out(tag, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        step;
        load_en   = 1'b0;
        m_imem[a] = d;
    endtask

    // In HALT: start and loads must have no effect on outputs or memory.
    task automatic halt_hold(input int pcb);
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = '0;
        load_data = $urandom;
        step;
        step;
        start   = 1'b0;
        load_en = 1'b0;
        chk_out("halt_hold", m_iw, pcb, 1'b0, 1'b0, 1'b1);
    endtask

    // zmode: 0 random alu_zero per slot, 1 forced 1, 2 forced 0.
    // stop_at >= 0 returns after checking that cycle, leaving the DUT in RUN.
    task automatic run_prog(input int max_slots, input int zmode, input bit junk, input int stop_at);
        int          pc, pn, t;
        bit          z;
        logic [31:0] w;
        start = 1'b1;
        step;
        start = 1'b0;
        t = 0;
        w = m_imem[0];
        if (is_halt(w)) begin
            chk_out("start_halt", m_iw, 0, 1'b0, 1'b0, 1'b1);
            halt_hold(0);
            return;
        end
        pc   = 0;
        m_iw = w;
        sat_inc();
        for (int s = 0; s < max_slots; s++) begin
            z = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            alu_zero = z;
            for (int c = 0; c < N; c++) begin
                chk_out("run", m_iw, pc * 4, c == 0, 1'b1, 1'b0);
                if (t == stop_at) begin
                    start = 1'b0;
                    load_en = 1'b0;
                    return;
                end
                t++;
                if (junk) begin
                    start     = 1'($urandom_range(0, 1));
                    load_en   = 1'($urandom_range(0, 1));
                    load_addr = AW'($urandom);
                    load_data = $urandom;
                end
                if (c < N - 1) step;
            end
            pn = model_next(pc, m_iw, z);
            w  = m_imem[pn];
            step;
            if (is_halt(w)) begin
                start   = 1'b0;
                load_en = 1'b0;
                chk_out("halt", m_iw, pn * 4, 1'b0, 1'b0, 1'b1);
                halt_hold(pn * 4);
                return;
            end
            pc   = pn;
            m_iw = w;
            sat_inc();
        end
        start   = 1'b0;
        load_en = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return {6'h3F, 26'($urandom)};
        if (r <= 3) return {6'd4, 10'($urandom), 16'($urandom)};
        if (r <= 5) return {6'd2, 26'($urandom)};
        if (r <= 9) return {6'h23, 26'($urandom)};
        return {6'h00, 26'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; load_en = 1'b0; alu_zero = 1'b0;
        load_addr = '0; load_data = '0;
        m_cnt = 0; m_iw = 32'd0;
        step;
        do_reset("reset");

        for (int a = 0; a < DEPTH; a++) load(a, 32'h0000_0020);

        // straight-line program ending on a halt word
        load(0, 32'h0022_1820); load(1, 32'h8C04_0004); load(2, 32'hFC00_0000);
        do_reset("t1.reset");
        run_prog(10, 0, 1'b0, -1);
        chk("t1.count", {16'd0, instr_count}, 32'd2);
        chk("t1.pc", pc_out, 32'h8);

        // jump
        do_reset("t2.reset");
        load(0, 32'h0800_0005); load(5, 32'h0000_0020); load(6, 32'hFC00_0000);
        run_prog(10, 0, 1'b0, -1);
        chk("t2.pc", pc_out, 32'h18);

        // beq taken (backward) and not taken
        do_reset("t3.reset");
        load(0, 32'h0800_0002); load(1, 32'h0000_0020); load(2, 32'h1000_FFFE); load(3, 32'hFC00_0000);
        run_prog(8, 1, 1'b0, -1);
        do_reset("t3b.reset");
        run_prog(8, 2, 1'b0, -1);
        chk("t3b.pc", pc_out, 32'hC);

        // pc wrap from 63 to 0
        do_reset("t4.reset");
        load(0, 32'h0800_003F); load(63, 32'h0000_0020); load(1, 32'hFC00_0000);
        run_prog(6, 0, 1'b0, -1);

        // reset mid-run at slot_cnt 2 of the second instruction, then replay
        do_reset("t5.reset");
        load(0, 32'h0000_0020); load(1, 32'h0122_0020); load(2, 32'hFC00_0000);
        run_prog(10, 0, 1'b0, N + 2);
        do_reset("t5.midreset");
        run_prog(10, 0, 1'b0, -1);
        chk("t5.count", {16'd0, instr_count}, 32'd2);

        // load with start is suppressed; loads in HALT are ignored
        do_reset("t6.reset");
        load(0, 32'hFC00_0000);
        load_en = 1'b1; start = 1'b1; load_addr = '0; load_data = 32'h0000_0020;
        step;
        load_en = 1'b0; start = 1'b0;
        chk_out("t6.ld_start", 32'd0, 0, 1'b0, 1'b0, 1'b1);
        halt_hold(0);
        do_reset("t6.reset2");
        run_prog(4, 0, 1'b0, -1);

        // random programs with spurious start/load during RUN and HALT
        for (int k = 0; k < 8; k++) begin
            do_reset("rnd.reset");
            for (int a = 0; a < DEPTH; a++) load(a, rand_word());
            run_prog(40, 0, 1'b1, -1);
            do_reset("rnd.replay_reset");
            run_prog(40, 0, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
